// File: rtl/rf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_arbiter
// Purpose  : Round-robin scheduler sharing one register-file read port among
//            NUM_REQ requesters. Drives the registered select of the shared
//            32:1 read mux and returns the captured word two cycles after
//            each grant, one grant per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rf_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         mux_select,
    input  logic [DATA_W-1:0]         mux_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam logic [NUM_REQ-1:0] C_ONE  = NUM_REQ'(1);
    localparam logic [ID_W-1:0]    C_LAST = ID_W'(NUM_REQ - 1);

    // Round-robin pointer: first requester examined on the next scan
    logic [ID_W-1:0]    r_ptr;

    // Stage 1: a read whose select is currently applied to the mux
    logic               r_s1_v;
    logic [ID_W-1:0]    r_s1_id;
    logic [ADDR_W-1:0]  r_mux_select;

    // Stage 2: registered response (r_rsp_valid doubles as the stage-2 valid)
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;

    // Grant scan results
    logic [ID_W-1:0]    w_scan;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_hs;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [ID_W-1:0]    w_ptr_next;

    // Scan ptr, ptr+1, ... (mod NUM_REQ) for the first valid request; frozen pipeline grants nothing
    always_comb begin
        w_scan   = '0;
        w_gnt_id = '0;
        w_hs     = 1'b0;
        if (!hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = ID_W'((int'(r_ptr) + k) % NUM_REQ);
                if (!w_hs && req_valid[w_scan]) begin
                    w_hs     = 1'b1;
                    w_gnt_id = w_scan;
                end
            end
        end
    end

    // The grant is a handshake by construction: it only lands on a valid requester
    assign req_ready  = w_hs ? (C_ONE << w_gnt_id) : '0;
    assign w_gnt_addr = req_addr[int'(w_gnt_id) * ADDR_W +: ADDR_W];
    assign w_ptr_next = (w_gnt_id == C_LAST) ? '0 : w_gnt_id + 1'b1;

    // Pointer moves just past the most recent winner, wrapping at NUM_REQ-1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Stage 1: apply the winner's address to the mux; select holds when idle or frozen
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v       <= 1'b0;
            r_s1_id      <= '0;
            r_mux_select <= '0;
        end else if (!hold) begin
            r_s1_v <= w_hs;
            if (w_hs) begin
                r_s1_id      <= w_gnt_id;
                r_mux_select <= w_gnt_addr;
            end
        end
    end

    // Stage 2: capture mux output (r0 forced to zero); id/data persist once valid drops
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else if (!hold) begin
            if (r_s1_v) begin
                r_rsp_valid <= C_ONE << r_s1_id;
                r_rsp_id    <= r_s1_id;
                r_rsp_data  <= (r_mux_select == '0) ? '0 : mux_data;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign mux_select = r_mux_select;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

endmodule
`default_nettype wire
